// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Holds the FSM state encoding and the hard-wired zero register index.
package pipeline_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. Clear has priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes and data-memory waits, plus saturating perf counters and a timeout flag.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_Rs1,
   input  logic [4:0]       IF_ID_Rs2,
   input  logic             IF_ID_useRs1,
   input  logic             IF_ID_useRs2,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             ID_EX_memRead,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_flush,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout,
   output state_t           fsm_state
);

   state_t          state, next_state;
   logic            mem_stall;
   logic            load_use;
   logic            wait_inc, wait_clr;
   logic            timeout_hit;
   logic [TO_W-1:0] wait_cnt;

   assign mem_stall = dmem_req & ~dmem_ready;

   assign load_use = ID_EX_memRead && (ID_EX_Rd != REG_ZERO) &&
                     ((IF_ID_useRs1 && (IF_ID_Rs1 == ID_EX_Rd)) ||
                      (IF_ID_useRs2 && (IF_ID_Rs2 == ID_EX_Rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Control outputs are purely combinational; reset forcing overrides everything.
   always_comb begin
      next_state    = mem_stall ? MEM_WAIT : RUN;
      PC_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_flush   = 1'b0;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      if (!rst_n) begin
         next_state    = RUN;
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_flush   = 1'b1;
         MEM_WB_bubble = 1'b1;
      end else if (mem_stall) begin
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         MEM_WB_bubble = 1'b1;
      end else if (branch_taken) begin
         // The dependent instruction of any load-use match is flushed here too.
         IF_ID_flush   = 1'b1;
         ID_EX_flush   = 1'b1;
      end else if (load_use) begin
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_flush   = 1'b1;
      end
   end

   assign wait_inc    = (state == MEM_WAIT) && mem_stall;
   assign wait_clr    = (state == MEM_WAIT) && !mem_stall;
   assign timeout_hit = (TIMEOUT != 0) && wait_inc && (int'(wait_cnt) >= TIMEOUT - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_timeout <= 1'b0;
      end else if (timeout_hit) begin
         mem_timeout <= 1'b1;
      end
   end

   sat_counter #(.W(TO_W)) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .count (wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!PC_write),
      .clr   (1'b0),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!mem_stall && branch_taken),
      .clr   (1'b0),
      .count (flush_count)
   );

   assign fsm_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a shortened memory timeout.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   localparam int CNT_W = 16;

   // Control bundle order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
   // ID_EX_flush, EX_MEM_write, MEM_WB_bubble.
   localparam logic [6:0] C_NORMAL = 7'b1101010;
   localparam logic [6:0] C_RESET  = 7'b0010101;
   localparam logic [6:0] C_LDUSE  = 7'b0001110;
   localparam logic [6:0] C_BRANCH = 7'b1111110;
   localparam logic [6:0] C_MWAIT  = 7'b0000001;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       rs1, rs2, rd;
   logic             use_rs1, use_rs2, mem_read, branch, req, ready;
   logic             pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, wb_bub;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic             mem_timeout;
   state_t           fsm_state;
   logic [6:0]       ctl;

   int n_vec = 0;
   int n_err = 0;

   assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, wb_bub};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4), .TO_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .IF_ID_Rs1     (rs1),
      .IF_ID_Rs2     (rs2),
      .IF_ID_useRs1  (use_rs1),
      .IF_ID_useRs2  (use_rs2),
      .ID_EX_Rd      (rd),
      .ID_EX_memRead (mem_read),
      .branch_taken  (branch),
      .dmem_req      (req),
      .dmem_ready    (ready),
      .PC_write      (pc_w),
      .IF_ID_write   (ifid_w),
      .IF_ID_flush   (ifid_f),
      .ID_EX_write   (idex_w),
      .ID_EX_flush   (idex_f),
      .EX_MEM_write  (exmem_w),
      .MEM_WB_bubble (wb_bub),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
      .mem_timeout   (mem_timeout),
      .fsm_state     (fsm_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic [4:0] s1, input logic [4:0] s2, input logic u1,
                          input logic u2, input logic [4:0] d, input logic mr);
      rs1 = s1; rs2 = s2; use_rs1 = u1; use_rs2 = u2; rd = d; mem_read = mr;
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int st, input int fl);
      chk({tag, "_stall"}, 32'(stall_cycles), 32'(st));
      chk({tag, "_flush"}, 32'(flush_count), 32'(fl));
   endtask

   initial begin
      rst_n = 1'b0; branch = 1'b0; req = 1'b0; ready = 1'b0;
      set_dec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("rst_ctl", 32'(ctl), 32'(C_RESET));
      chk("rst_state", 32'(fsm_state), 32'(RUN));
      chk("rst_to", 32'(mem_timeout), 32'd0);
      chk_cnt("rst", 0, 0);
      tick();
      tick();
      rst_n = 1'b1;

      // No hazard: load in EX but decode does not depend on it.
      set_dec(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1);
      chk("idle_ctl", 32'(ctl), 32'(C_NORMAL));
      tick();
      chk_cnt("idle", 0, 0);

      // rs1 load-use: one bubble, then the bubble clears memRead.
      set_dec(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1);
      chk("lu1_ctl", 32'(ctl), 32'(C_LDUSE));
      tick();
      chk_cnt("lu1", 1, 0);
      set_dec(5'd5, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
      chk("lu1_after_ctl", 32'(ctl), 32'(C_NORMAL));
      tick();
      chk_cnt("lu1_after", 1, 0);

      // x0 destination never stalls.
      set_dec(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
      chk("rd0_ctl", 32'(ctl), 32'(C_NORMAL));
      tick();
      chk_cnt("rd0", 1, 0);

      // rs2 match only counts when rs2 is actually read.
      set_dec(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1);
      chk("rs2_unused_ctl", 32'(ctl), 32'(C_NORMAL));
      set_dec(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1);
      chk("rs2_used_ctl", 32'(ctl), 32'(C_LDUSE));
      tick();
      chk_cnt("rs2", 2, 0);

      // Branch overrides a load-use match.
      set_dec(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1);
      branch = 1'b1;
      #1;
      chk("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
      tick();
      chk_cnt("br_lu", 2, 1);

      // Memory wait with branch held: three frozen cycles, then the flush fires.
      set_dec(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
      req = 1'b1; ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mw%0d_ctl", i), 32'(ctl), 32'(C_MWAIT));
         tick();
         chk($sformatf("mw%0d_state", i), 32'(fsm_state), 32'(MEM_WAIT));
      end
      chk_cnt("mw", 5, 1);
      ready = 1'b1;
      #1;
      chk("mw_done_ctl", 32'(ctl), 32'(C_BRANCH));
      tick();
      chk("mw_done_state", 32'(fsm_state), 32'(RUN));
      chk_cnt("mw_done", 5, 2);
      branch = 1'b0; req = 1'b0; ready = 1'b0;
      #1;

      // Timeout: flag rises after the 4th consecutive MEM_WAIT cycle and sticks.
      req = 1'b1;
      #1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("to_c%0d", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
      end
      chk_cnt("to", 11, 2);
      ready = 1'b1;
      #1;
      chk("to_ready_ctl", 32'(ctl), 32'(C_NORMAL));
      tick();
      chk("to_sticky", 32'(mem_timeout), 32'd1);
      chk("to_state", 32'(fsm_state), 32'(RUN));
      ready = 1'b0;
      #1;

      // Asynchronous reset in the middle of a wait.
      tick();
      chk("mid_state", 32'(fsm_state), 32'(MEM_WAIT));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_ctl", 32'(ctl), 32'(C_RESET));
      chk("async_state", 32'(fsm_state), 32'(RUN));
      chk("async_to", 32'(mem_timeout), 32'd0);
      chk_cnt("async", 0, 0);
      req = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ctl", 32'(ctl), 32'(C_NORMAL));
      tick();
      chk_cnt("post_rst", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
